// File: rtl/ea_agu.sv
`default_nettype none
// ============================================================================
//  Module      : ea_agu
//  Description : Registered LC3 effective-address generation unit.
//                EA = (PC | RS1) + sign-extended IR offset (0/offA/offB/offC)
//                behind a valid/ready request handshake, with an optional
//                indirect mode that replaces EA by the memory word at the
//                computed address (LDI/STI pointer fetch).
//                Optional feature macro: EA_WRAP_FLAG_EN adds the registered
//                output ea_wrap (base+offset left the 0..2^WIDTH-1 range).
//  Revision    : 1.0 - initial release
// ============================================================================
module ea_agu #(
  parameter int WIDTH      = 16,
  parameter int OFF_A_BITS = 6,
  parameter int OFF_B_BITS = 9,
  parameter int OFF_C_BITS = 11
) (
  input  logic             clk,
  input  logic             reset,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] ir,
  input  logic [2:0]       control,
  input  logic             indirect,
  // memory read port (pointer fetch)
  output logic             mem_rd_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_rd_ack,
  input  logic [WIDTH-1:0] mem_rd_data,
  // result side
  output logic             ea_valid,
  input  logic             ea_ready,
  output logic [WIDTH-1:0] ea
`ifdef EA_WRAP_FLAG_EN
  ,
  output logic             ea_wrap
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_ea;

  logic [WIDTH-1:0] w_off_a;
  logic [WIDTH-1:0] w_off_b;
  logic [WIDTH-1:0] w_off_c;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_off;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum;
  logic             w_load_sum;
  logic             w_load_mem;

  // Offset fields, each sign-extended from its own top bit.
  assign w_off_a = {{(WIDTH-OFF_A_BITS){ir[OFF_A_BITS-1]}}, ir[OFF_A_BITS-1:0]};
  assign w_off_b = {{(WIDTH-OFF_B_BITS){ir[OFF_B_BITS-1]}}, ir[OFF_B_BITS-1:0]};
  assign w_off_c = {{(WIDTH-OFF_C_BITS){ir[OFF_C_BITS-1]}}, ir[OFF_C_BITS-1:0]};

  // Base and offset selection from the control word.
  always_comb begin
    w_base = control[2] ? rs1_data : pc;
    w_off  = '0;
    case (control[1:0])
      2'b00:   w_off = '0;
      2'b01:   w_off = w_off_a;
      2'b10:   w_off = w_off_b;
      default: w_off = w_off_c;
    endcase
  end

  // One extra bit keeps the carry out, needed only for the wrap flag.
  assign w_sum_ext = {1'b0, w_base} + {1'b0, w_off};
  assign w_sum     = w_sum_ext[WIDTH-1:0];

`ifdef EA_WRAP_FLAG_EN
  logic w_wrap;
  logic r_wrap;

  // Non-negative offset wraps on carry out; negative offset wraps on borrow,
  // which in two's complement addition shows up as a missing carry.
  assign w_wrap  = w_off[WIDTH-1] ? ~w_sum_ext[WIDTH] : w_sum_ext[WIDTH];
  assign ea_wrap = r_wrap;

  // Wrap flag is captured with the pointer/address computation only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else if (w_load_sum) begin
      r_wrap <= w_wrap;
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, ir[WIDTH-1:OFF_C_BITS]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, ir[WIDTH-1:OFF_C_BITS], w_sum_ext[WIDTH]};
`endif

  // State register; reset returns to IDLE immediately, dropping all strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs. In OUT the unit can take a new request
  // on the same edge the consumer drains the result, so direct results can
  // stream one per cycle.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    mem_rd_req   = 1'b0;
    mem_addr     = '0;
    ea_valid     = 1'b0;
    w_load_sum   = 1'b0;
    w_load_mem   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_load_sum   = 1'b1;
          w_state_next = indirect ? ST_FETCH : ST_OUT;
        end
      end
      ST_FETCH: begin
        mem_rd_req = 1'b1;
        mem_addr   = r_ea;
        if (mem_rd_ack) begin
          w_load_mem   = 1'b1;
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        ea_valid  = 1'b1;
        req_ready = ea_ready;
        if (ea_ready) begin
          if (req_valid) begin
            w_load_sum   = 1'b1;
            w_state_next = indirect ? ST_FETCH : ST_OUT;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address register: computed sum on accept, fetched pointer on read ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ea <= '0;
    end else if (w_load_sum) begin
      r_ea <= w_sum;
    end else if (w_load_mem) begin
      r_ea <= mem_rd_data;
    end
  end

  assign ea = r_ea;

endmodule
`default_nettype wire

// File: tb/tb_ea_agu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ea_agu
//  Description : Scoreboard testbench for ea_agu (direct, back-to-back,
//                indirect, backpressure, wrap and reset-mid-fetch scenarios).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ea_agu;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] ea;
    logic             wrap;
  } sb_t;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] ir;
  logic [2:0]       control;
  logic             indirect;
  logic             mem_rd_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_rd_ack;
  logic [WIDTH-1:0] mem_rd_data;
  logic             ea_valid;
  logic             ea_ready;
  logic [WIDTH-1:0] ea;
`ifdef EA_WRAP_FLAG_EN
  logic             ea_wrap;
`endif

  sb_t sb[$];
  sb_t exp_item;
  sb_t tmp_item;
  int  n_checks;
  int  n_pass;

  ea_agu #(
    .WIDTH      (WIDTH),
    .OFF_A_BITS (6),
    .OFF_B_BITS (9),
    .OFF_C_BITS (11)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .ir          (ir),
    .control     (control),
    .indirect    (indirect),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .ea_valid    (ea_valid),
    .ea_ready    (ea_ready),
    .ea          (ea)
`ifdef EA_WRAP_FLAG_EN
    ,
    .ea_wrap     (ea_wrap)
`endif
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  // Reference model using signed integer arithmetic.
  function automatic sb_t model(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] r,
                                input logic [WIDTH-1:0] i, input logic [2:0] c);
    int  base;
    int  off;
    int  s;
    sb_t m;
    base = c[2] ? int'(r) : int'(p);
    case (c[1:0])
      2'd0:    off = 0;
      2'd1:    off = int'(i[5:0])  - (i[5]  ? 64   : 0);
      2'd2:    off = int'(i[8:0])  - (i[8]  ? 512  : 0);
      default: off = int'(i[10:0]) - (i[10] ? 2048 : 0);
    endcase
    s      = base + off;
    m.ea   = s[WIDTH-1:0];
    m.wrap = (s < 0) || (s > 65535);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] r,
                           input logic [WIDTH-1:0] i, input logic [2:0] c,
                           input logic ind);
    req_valid = 1'b1;
    pc        = p;
    rs1_data  = r;
    ir        = i;
    control   = c;
    indirect  = ind;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #23;
    reset = 1'b0;
    tick();
    n_checks++; if (ea_valid !== 1'b0)   $display("FAIL reset_ea_valid: got %b want 0", ea_valid);   else n_pass++;
    n_checks++; if (mem_rd_req !== 1'b0) $display("FAIL reset_mem_rd_req: got %b want 0", mem_rd_req); else n_pass++;
    n_checks++; if (ea !== 16'h0000)     $display("FAIL reset_ea: got %h want 0000", ea);             else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else n_pass++;
    n_checks++; if (req_ready !== 1'b1)  $display("FAIL reset_req_ready: got %b want 1", req_ready);  else n_pass++;
  endtask

  task automatic test_direct();
    drive_req(16'h3000, 16'h0000, 16'h01FF, 3'b010, 1'b0);
    sb.push_back(model(pc, rs1_data, ir, control));
    n_checks++; if (req_ready !== 1'b1) $display("FAIL direct_req_ready_idle: got %b want 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++; if (ea_valid !== 1'b1) $display("FAIL direct_ea_valid: got %b want 1", ea_valid); else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL direct_ea: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL direct_ea: got %h want %h", ea, exp_item.ea); else n_pass++;
`ifdef EA_WRAP_FLAG_EN
      n_checks++; if (ea_wrap !== exp_item.wrap) $display("FAIL direct_wrap: got %b want %b", ea_wrap, exp_item.wrap); else n_pass++;
`endif
    end
    n_checks++; if (req_ready !== 1'b1) $display("FAIL direct_req_ready_out: got %b want 1", req_ready); else n_pass++;
    tick();
    n_checks++; if (ea_valid !== 1'b0) $display("FAIL direct_drain: got %b want 0", ea_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_req(16'h0000, 16'h4000, 16'h0020, 3'b101, 1'b0);
    sb.push_back(model(pc, rs1_data, ir, control));
    tick();
    n_checks++; if (ea_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", ea_valid); else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL b2b_first_ea: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL b2b_first_ea: got %h want %h", ea, exp_item.ea); else n_pass++;
    end
    control = 3'b100;
    sb.push_back(model(pc, rs1_data, ir, control));
    n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_req_ready: got %b want 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++; if (ea_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b want 1", ea_valid); else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL b2b_second_ea: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL b2b_second_ea: got %h want %h", ea, exp_item.ea); else n_pass++;
    end
    tick();
  endtask

  task automatic test_indirect();
    drive_req(16'h3000, 16'h0000, 16'h0005, 3'b010, 1'b1);
    tmp_item = model(pc, rs1_data, ir, control);
    tick();
    req_valid = 1'b0;
    indirect  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (mem_rd_req !== 1'b1) $display("FAIL ind_mem_rd_req[%0d]: got %b want 1", k, mem_rd_req); else n_pass++;
      n_checks++; if (mem_addr !== 16'h3005) $display("FAIL ind_mem_addr[%0d]: got %h want 3005", k, mem_addr); else n_pass++;
      n_checks++; if (ea_valid !== 1'b0) $display("FAIL ind_early_valid[%0d]: got %b want 0", k, ea_valid); else n_pass++;
      tick();
    end
    mem_rd_ack  = 1'b1;
    mem_rd_data = 16'h1234;
    tmp_item.ea = mem_rd_data;
    sb.push_back(tmp_item);
    tick();
    mem_rd_ack  = 1'b0;
    n_checks++; if (ea_valid !== 1'b1) $display("FAIL ind_valid: got %b want 1", ea_valid); else n_pass++;
    n_checks++; if (mem_rd_req !== 1'b0) $display("FAIL ind_req_drop: got %b want 0", mem_rd_req); else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL ind_ea: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL ind_ea: got %h want %h", ea, exp_item.ea); else n_pass++;
`ifdef EA_WRAP_FLAG_EN
      n_checks++; if (ea_wrap !== exp_item.wrap) $display("FAIL ind_wrap: got %b want %b", ea_wrap, exp_item.wrap); else n_pass++;
`endif
    end
    tick();
    // Minimum-latency pointer fetch: acknowledge in the first FETCH cycle.
    drive_req(16'h0000, 16'h0100, 16'h0000, 3'b100, 1'b1);
    tmp_item = model(pc, rs1_data, ir, control);
    tick();
    req_valid   = 1'b0;
    indirect    = 1'b0;
    mem_rd_ack  = 1'b1;
    mem_rd_data = 16'hABCD;
    tmp_item.ea = mem_rd_data;
    sb.push_back(tmp_item);
    n_checks++; if (mem_addr !== 16'h0100) $display("FAIL ind_fast_addr: got %h want 0100", mem_addr); else n_pass++;
    tick();
    mem_rd_ack = 1'b0;
    n_checks++; if (ea_valid !== 1'b1) $display("FAIL ind_fast_valid: got %b want 1", ea_valid); else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL ind_fast_ea: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL ind_fast_ea: got %h want %h", ea, exp_item.ea); else n_pass++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    ea_ready = 1'b0;
    drive_req(16'h0000, 16'h1000, 16'h003F, 3'b101, 1'b0);
    sb.push_back(model(pc, rs1_data, ir, control));
    tick();
    // A competing request that must not be taken while the result is held.
    drive_req(16'h5555, 16'h0000, 16'h0000, 3'b000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (ea_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", k, ea_valid); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", k, req_ready); else n_pass++;
      n_checks++;
      if (sb.size() == 0) $display("FAIL bp_ea[%0d]: got %h want scoreboard entry (empty)", k, ea);
      else if (ea !== sb[0].ea) $display("FAIL bp_ea[%0d]: got %h want %h", k, ea, sb[0].ea);
      else n_pass++;
      tick();
    end
    req_valid = 1'b0;
    ea_ready  = 1'b1;
    n_checks++;
    if (sb.size() == 0) $display("FAIL bp_ea_final: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL bp_ea_final: got %h want %h", ea, exp_item.ea); else n_pass++;
    end
    tick();
    n_checks++; if (ea_valid !== 1'b0) $display("FAIL bp_not_accepted: got %b want 0", ea_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    drive_req(16'hFFFF, 16'h0000, 16'h0001, 3'b011, 1'b0);
    sb.push_back(model(pc, rs1_data, ir, control));
    tick();
    // Negative offset borrowing below zero, taken back-to-back.
    drive_req(16'h0000, 16'h0000, 16'h07FF, 3'b011, 1'b0);
    sb.push_back(model(pc, rs1_data, ir, control));
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ea_valid !== 1'b1) $display("FAIL wrap_valid[%0d]: got %b want 1", k, ea_valid); else n_pass++;
      n_checks++;
      if (sb.size() == 0) $display("FAIL wrap_ea[%0d]: got %h want scoreboard entry (empty)", k, ea);
      else begin
        exp_item = sb.pop_front();
        if (ea !== exp_item.ea) $display("FAIL wrap_ea[%0d]: got %h want %h", k, ea, exp_item.ea); else n_pass++;
`ifdef EA_WRAP_FLAG_EN
        n_checks++; if (ea_wrap !== exp_item.wrap) $display("FAIL wrap_flag[%0d]: got %b want %b", k, ea_wrap, exp_item.wrap); else n_pass++;
`endif
      end
      tick();
      req_valid = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    drive_req(16'h2000, 16'h0000, 16'h0003, 3'b001, 1'b1);
    tick();
    req_valid = 1'b0;
    indirect  = 1'b0;
    n_checks++; if (mem_rd_req !== 1'b1) $display("FAIL rst_fetch_entered: got %b want 1", mem_rd_req); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_rd_req !== 1'b0) $display("FAIL rst_async_mem_rd_req: got %b want 0", mem_rd_req); else n_pass++;
    n_checks++; if (ea_valid !== 1'b0)   $display("FAIL rst_async_ea_valid: got %b want 0", ea_valid);   else n_pass++;
    n_checks++; if (ea !== 16'h0000)     $display("FAIL rst_async_ea: got %h want 0000", ea);           else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL rst_async_mem_addr: got %h want 0000", mem_addr); else n_pass++;
    tick();
    reset = 1'b0;
    mem_rd_ack  = 1'b1;
    mem_rd_data = 16'hBEEF;
    tick();
    mem_rd_ack = 1'b0;
    n_checks++; if (ea_valid !== 1'b0)   $display("FAIL rst_late_ack_valid: got %b want 0", ea_valid);   else n_pass++;
    n_checks++; if (req_ready !== 1'b1)  $display("FAIL rst_req_ready: got %b want 1", req_ready);       else n_pass++;
    drive_req(16'h3000, 16'h0000, 16'h0010, 3'b001, 1'b0);
    sb.push_back(model(pc, rs1_data, ir, control));
    tick();
    req_valid = 1'b0;
    n_checks++; if (ea_valid !== 1'b1) $display("FAIL rst_next_valid: got %b want 1", ea_valid); else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL rst_next_ea: got %h want scoreboard entry (empty)", ea);
    else begin
      exp_item = sb.pop_front();
      if (ea !== exp_item.ea) $display("FAIL rst_next_ea: got %h want %h", ea, exp_item.ea); else n_pass++;
    end
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    pc          = '0;
    rs1_data    = '0;
    ir          = '0;
    control     = 3'b000;
    indirect    = 1'b0;
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;
    ea_ready    = 1'b1;

    test_reset();
    test_direct();
    test_back_to_back();
    test_indirect();
    test_backpressure();
    test_wrap();
    test_reset_mid_fetch();

    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained: got %0d entries want 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ea_agu.md
Name: ea_agu

Overview:
- Parametrised, registered effective-address generation unit for the LC3 datapath.
- Computes base + sign-extended IR offset, with base PC or RS1 and offset 0, off6, off9 or off11.
- Adds a valid/ready request/response handshake.
- Adds an indirect mode that fetches the final address through a memory read port (LDI/STI pointer fetch).
- Sits between decode/register-read and the memory stage.

Parameters:
- WIDTH, 16, address/data width of PC, RS1_DATA, EA, MEM_ADDR, MEM_RD_DATA.
- OFF_A_BITS, 6, width of offset A (IR[OFF_A_BITS-1:0]).
- OFF_B_BITS, 9, width of offset B (IR[OFF_B_BITS-1:0]).
- OFF_C_BITS, 11, width of offset C (IR[OFF_C_BITS-1:0]); must be < WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  unit accepts request this cycle.
- PC  input  WIDTH  program counter base.
- RS1_DATA  input  WIDTH  register base.
- IR  input  WIDTH  instruction word; offsets taken from its low bits.
- CONTROL  input  3  [2]: base select, 0=PC, 1=RS1. [1:0]: 00=zero, 01=offA, 10=offB, 11=offC.
- INDIRECT  input  1  1 = result is the memory word at the computed address.
- MEM_RD_REQ  output  1  memory read request.
- MEM_ADDR  output  WIDTH  memory read address.
- MEM_RD_ACK  input  1  read data valid this cycle.
- MEM_RD_DATA  input  WIDTH  read data.
- EA_VALID  output  1  EA holds a result.
- EA_READY  input  1  consumer takes EA.
- EA  output  WIDTH  effective address.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Offsets: sign-extended from the top IR bit of each field to WIDTH.
- Sum: base + offset mod 2^WIDTH; carry is discarded.
- All request inputs are sampled only on the accept edge (REQ_VALID & REQ_READY) and are ignored otherwise.
- States:
  - IDLE: REQ_READY=1. On accept: EA_REG<=sum; go to FETCH if INDIRECT, else OUT.
  - FETCH: MEM_RD_REQ=1, MEM_ADDR=EA_REG, held stable until MEM_RD_ACK. On ACK: EA_REG<=MEM_RD_DATA, go to OUT. MEM_RD_ACK is ignored outside FETCH.
  - OUT: EA_VALID=1, EA=EA_REG held stable.
    - EA_READY=1 with no new accept: go to IDLE.
    - REQ_READY = EA_READY (combinational). If REQ_VALID & EA_READY, accept the new request on the same edge (load EA_REG, go to FETCH or OUT). This gives back-to-back direct results every cycle.
- Latency: direct, EA_VALID the cycle after accept. Indirect, EA_VALID the cycle after MEM_RD_ACK. A same-cycle ACK is allowed, giving a minimum indirect latency of 2 cycles.
- MEM_RD_REQ is never asserted outside FETCH. At most one read is outstanding.
- Reset values, including reset mid-FETCH or mid-OUT:
  - State returns to IDLE immediately.
  - MEM_RD_REQ=0, EA_VALID=0, EA=0, MEM_ADDR=0.
  - REQ_READY=1 once reset deasserts.
  - A late MEM_RD_ACK after reset is ignored.

Optional Feature:
EA_WRAP_FLAG_EN: adds output port EA_WRAP (1 bit), registered alongside EA.
- EA_WRAP=1 when the base+offset addition left the range 0..2^WIDTH-1, i.e. it carried out for a non-negative offset or borrowed for a negative offset.
- For an indirect request, EA_WRAP reflects the pointer-address computation.
- EA_WRAP resets to 0.
- Without the macro, the port is absent and wrap is silent.

Test Plan:
- Direct PC+off9: PC=0x3000, IR=0x01FF (off9=-1), CONTROL=3'b010, INDIRECT=0 -> EA_VALID next cycle, EA=0x2FFF; REQ_READY stays 1 with EA_READY=1.
- RS1+off6 back-to-back: RS1=0x4000, IR=0x0020 (off6=-32), CONTROL=3'b101 -> EA=0x3FE0. A second request the following cycle (CONTROL=3'b100) -> EA=0x4000. No bubble.
- Indirect with 3-cycle memory delay: PC=0x3000, IR=0x0005, CONTROL=3'b010, INDIRECT=1 -> MEM_RD_REQ=1, MEM_ADDR=0x3005 held for 3 cycles. ACK with data 0x1234 -> EA_VALID next cycle, EA=0x1234.
- Backpressure: EA_READY=0 for 5 cycles after result -> EA_VALID and EA stable, REQ_READY=0, a new REQ_VALID is not accepted.
- Wrap: PC=0xFFFF, IR=0x0001, CONTROL=3'b011 (offC=+1) -> EA=0x0000. With EA_WRAP_FLAG_EN, EA_WRAP=1.
- Reset mid-FETCH: assert RESET while MEM_RD_REQ=1 -> MEM_RD_REQ and EA_VALID drop asynchronously. A subsequent MEM_RD_ACK causes no EA_VALID. The next request works normally.
